key_event_queue: RTL and testbench

Consumes the single-cycle key_pulse outputs of NUM_KEYS debouncer instances and turns them into an ordered stream of key-code events. Presses are latched per key, so none are lost while the consumer is busy. Simultaneous presses are serialised by fixed priority, and the resulting events are buffered in a small FIFO. The output is a valid/ready stream read by the game/menu control FSM.

---
 rtl/key_evt_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/key_event_queue.sv | 71 +++++++
 tb/tb_key_event_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared types and priority encoder for the key event queue
package key_evt_pkg;

    localparam int NUM_KEYS_DEF   = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CODE_W_DEF     = $clog2(NUM_KEYS_DEF);

    typedef logic [CODE_W_DEF-1:0] key_code_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } lowest_t;

    // Scan from the top down so the lowest set bit is the last one written.
    function automatic lowest_t lowest_set(input logic [15:0] vec);
        lowest_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign valid     = (r_count != '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && valid;
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - latches key presses and serialises them into an event FIFO
module key_event_queue
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int CODE_W    = $clog2(NUM_KEYS),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_pulse,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CODE_W-1:0]   evt_code,
    output logic [CNT_W-1:0]    evt_count,
    output logic                overflow,
    input  logic                clr_overflow
);

    logic [NUM_KEYS-1:0] r_pending;
    logic                r_overflow;
    logic [15:0]         w_vec;
    lowest_t             w_low;
    logic [CODE_W-1:0]   w_sel;
    logic                w_full;
    logic                w_push;
    logic [NUM_KEYS-1:0] w_clr_mask;
    logic                w_merge;

    always_comb begin
        w_vec                 = '0;
        w_vec[NUM_KEYS-1:0]   = r_pending;
        w_low                 = lowest_set(w_vec);
        w_sel                 = CODE_W'(w_low.idx);
        w_push                = w_low.found && !w_full;
        w_clr_mask            = '0;
        if (w_push) w_clr_mask[w_sel] = 1'b1;
        // A press on a bit that stays pending this cycle is lost.
        w_merge               = |(key_pulse & r_pending & ~w_clr_mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | key_pulse;
            if (w_merge)           r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (w_push),
        .push_data (w_sel),
        .pop       (evt_ready),
        .pop_data  (evt_code),
        .valid     (evt_valid),
        .full      (w_full),
        .count     (evt_count)
    );

    assign overflow = r_overflow;

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - randomized and directed checks of key_event_queue against a queue model
module tb_key_event_queue;
    import key_evt_pkg::*;

    localparam int NK    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NK-1:0] key_pulse = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [1:0]    evt_code;
    logic [3:0]    evt_count;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    int tests = 0;
    int fails = 0;

    key_code_t     m_q[$];
    logic [NK-1:0] m_pend = '0;
    logic          m_ov = 1'b0;

    always #5 clk = ~clk;

    key_event_queue #(.NUM_KEYS(NK), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_pulse    (key_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, from the pre-edge state and inputs.
    task automatic model_update(input logic [NK-1:0] pulse, input logic rdy, input logic clr);
        bit pop, push, merged;
        int sel;
        pop  = (m_q.size() != 0) && rdy;
        push = (m_pend != 0) && (m_q.size() < DEPTH);
        sel  = -1;
        for (int i = NK - 1; i >= 0; i--) if (m_pend[i]) sel = i;
        merged = 0;
        for (int i = 0; i < NK; i++)
            if (pulse[i] && m_pend[i] && !(push && sel == i)) merged = 1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(key_code_t'(sel));
            m_pend[sel] = 1'b0;
        end
        m_pend = m_pend | pulse;
        if (merged) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
    endtask

    task automatic compare();
        chk("valid", int'(evt_valid), int'(m_q.size() != 0));
        chk("count", int'(evt_count), m_q.size());
        chk("overflow", int'(overflow), int'(m_ov));
        chk("pending", int'(dut.r_pending), int'(m_pend));
        if (m_q.size() != 0) chk("code", int'(evt_code), int'(m_q[0]));
    endtask

    task automatic step(input logic [NK-1:0] pulse, input logic rdy, input logic clr);
        key_pulse    = pulse;
        evt_ready    = rdy;
        clr_overflow = clr;
        @(posedge clk);
        model_update(pulse, rdy, clr);
        @(negedge clk);
        compare();
    endtask

    int got[$];
    int exp9[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
    int guard;

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        compare();

        // Idle after reset
        for (int i = 0; i < 20; i++) step('0, 1'b0, 1'b0);
        chk("t1_valid", int'(evt_valid), 0);
        chk("t1_count", int'(evt_count), 0);
        chk("t1_ovf", int'(overflow), 0);

        // Single press, two cycles to valid
        step(4'b0100, 1'b1, 1'b0);
        chk("t2_valid_k", int'(evt_valid), 0);
        step('0, 1'b1, 1'b0);
        chk("t2_valid_k1", int'(evt_valid), 1);
        chk("t2_code", int'(evt_code), 2);
        step('0, 1'b1, 1'b0);
        chk("t2_count_after_pop", int'(evt_count), 0);

        // Simultaneous presses serialise lowest index first
        step(4'b1011, 1'b0, 1'b0);
        chk("t3_count0", int'(evt_count), 0);
        for (int n = 1; n <= 3; n++) begin
            step('0, 1'b0, 1'b0);
            chk("t3_count_ramp", int'(evt_count), n);
        end
        chk("t3_head0", int'(evt_code), 0);
        step('0, 1'b1, 1'b0);
        chk("t3_head1", int'(evt_code), 1);
        step('0, 1'b1, 1'b0);
        chk("t3_head3", int'(evt_code), 3);
        step('0, 1'b1, 1'b0);
        chk("t3_empty", int'(evt_count), 0);

        // Fill and backpressure
        for (int i = 0; i < 8; i++) begin
            step(NK'(1 << (i % NK)), 1'b0, 1'b0);
            step('0, 1'b0, 1'b0);
        end
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        chk("t4_count", int'(evt_count), 8);
        chk("t4_pend1", int'(dut.r_pending[1]), 1);
        chk("t4_ovf", int'(overflow), 1);
        got.delete();
        guard = 0;
        while (got.size() < 9 && guard < 40) begin
            if (evt_valid) got.push_back(int'(evt_code));
            step('0, 1'b1, 1'b0);
            guard++;
        end
        chk("t4_drain_done", got.size(), 9);
        for (int i = 0; i < got.size() && i < 9; i++) chk("t4_drain_code", got[i], exp9[i]);

        // Overflow clear and set-wins precedence
        for (int i = 0; i < 8; i++) begin
            step(NK'(1 << (i % NK)), 1'b0, 1'b0);
            step('0, 1'b0, 1'b0);
        end
        step(4'b0001, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        chk("t5_cleared", int'(overflow), 0);
        step(4'b0001, 1'b0, 1'b1);
        chk("t5_set_wins", int'(overflow), 1);
        step('0, 1'b0, 1'b1);
        chk("t5_clear", int'(overflow), 0);

        // Async reset between edges
        guard = 0;
        while (m_q.size() > 5 && guard < 20) begin
            step('0, 1'b1, 1'b0);
            guard++;
        end
        step(4'b0100, 1'b0, 1'b0);
        chk("t6_count_pre", int'(evt_count), 5);
        chk("t6_pend_pre", int'(dut.r_pending), 4);
        reset_n = 1'b0;
        #1;
        chk("t6_valid", int'(evt_valid), 0);
        chk("t6_count", int'(evt_count), 0);
        chk("t6_pend", int'(dut.r_pending), 0);
        m_q.delete();
        m_pend = '0;
        m_ov   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        compare();

        // Randomized traffic with alternating stall phases
        for (int i = 0; i < 1500; i++) begin
            logic [NK-1:0] p;
            logic r;
            p = (($urandom % 4) == 0) ? NK'($urandom) : '0;
            if (((i / 150) % 2) == 1) r = (($urandom % 8) == 0);
            else                      r = (($urandom % 4) != 0);
            step(p, r, (($urandom % 16) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
